// File: rtl/arb_pkg.sv
// Shared types and defaults for the grant-lock stage that follows the fixed-priority arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int ARB_N        = 4;
  localparam int ARB_MAX_HOLD = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot select to binary index, plus selection of the selected requester's last/req bits.
module onehot_to_bin
  import arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  onehot,
  input  logic [N-1:0]  last,
  input  logic [N-1:0]  req,
  output logic [IW-1:0] bin,
  output logic          last_sel,
  output logic          req_sel
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) bin = bin | IW'(i);
    end
  end

  assign last_sel = |(onehot & last);
  assign req_sel  = |(onehot & req);

endmodule

// File: rtl/arbiter_grant_lock.sv
// Locks the arbiter's grant for a whole transaction, releases on last/req-drop/hold
// timeout and inserts one turnaround cycle before the next grant. N must be >= 2.
module arbiter_grant_lock
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          grant_in,
  input  logic [N-1:0]          last,
  output logic [N-1:0]          grant,
  output logic [clog2(N)-1:0]   owner_id,
  output logic                  bus_busy,
  output logic                  timeout
);

  localparam int IW = clog2(N);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  function automatic logic [N-1:0] lowest_set(input logic [N-1:0] v);
    return v & (~v + N'(1));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [N-1:0]     pick, sel, grant_d;
  logic [IW-1:0]    sel_id, owner_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, timeout_d;
  logic             own_last, own_req, hold_expired, release_own;

  // A malformed multi-hot grant_in is reduced to its lowest set bit.
  assign pick = lowest_set(grant_in);

  // While owning, the selector points at the locked owner; otherwise at the candidate.
  assign sel = (state_q == OWN) ? grant : pick;

  onehot_to_bin #(.N(N), .IW(IW)) u_sel (
    .onehot   (sel),
    .last     (last),
    .req      (req),
    .bin      (sel_id),
    .last_sel (own_last),
    .req_sel  (own_req)
  );

  assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
  assign release_own  = own_last || !own_req || hold_expired;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    owner_id_d = owner_id;
    busy_d     = bus_busy;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      OWN: begin
        if (release_own) begin
          state_d   = GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = hold_expired && !own_last;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        if (|pick) begin
          state_d    = OWN;
          grant_d    = pick;
          owner_id_d = sel_id;
          busy_d     = 1'b1;
          cnt_d      = '0;
        end else begin
          state_d    = IDLE;
          grant_d    = '0;
          owner_id_d = '0;
          busy_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant    <= '0;
      owner_id <= '0;
      bus_busy <= 1'b0;
      timeout  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      owner_id <= owner_id_d;
      bus_busy <= busy_d;
      timeout  <= timeout_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_arbiter_grant_lock.sv
// Randomized bench for arbiter_grant_lock against an ownership-level reference model.
module tb_arbiter_grant_lock;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 8;
  localparam int CYCLES   = 4000;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, grant_in, last, grant;
  logic [1:0]   owner_id;
  logic         bus_busy, timeout;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: who owns the bus, for how many cycles so far, last reported owner.
  int m_own  = -1;
  int m_held = 0;
  int m_id   = 0;
  bit m_to   = 1'b0;

  always #5 clk = ~clk;

  arbiter_grant_lock #(.N(N), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant_in (grant_in),
    .last     (last),
    .grant    (grant),
    .owner_id (owner_id),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    return (m_own >= 0) ? (N'(1) << m_own) : '0;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] gi,
                            input logic [N-1:0] ls);
    bit expired;
    if (r) begin
      m_own = -1; m_held = 0; m_id = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_own >= 0) begin
      expired = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (ls[m_own] || !rq[m_own] || expired) begin
        m_to  = expired && !ls[m_own];
        m_own = -1;
      end else begin
        m_held++;
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) if (gi[i]) m_own = i;
      if (m_own >= 0) begin
        m_held = 1;
        m_id   = m_own;
      end else begin
        m_id = 0;
      end
    end
  endtask

  initial begin
    int mode, tog, lp;
    rst = 1'b1; req = '0; grant_in = '0; last = '0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      cyc = c;
      chk("grant",    32'(grant),    32'(exp_grant()));
      chk("owner_id", 32'(owner_id), 32'(m_id));
      chk("bus_busy", 32'(bus_busy), 32'(m_own >= 0));
      chk("timeout",  32'(timeout),  32'(m_to));

      mode = (c / 250) % 4;
      tog  = (mode == 0) ? 6 : (mode == 1) ? 60 : 30;
      lp   = (mode == 0) ? 8 : (mode == 1) ? 1000 : (mode == 2) ? 20 : 12;

      rst = (c < 2) || ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) if ($urandom_range(0, tog) == 0) req[i] = ~req[i];

      if ($urandom_range(0, 9) == 0) begin
        grant_in = N'($urandom_range(0, (1 << N) - 1));
      end else begin
        grant_in = '0;
        for (int i = N - 1; i >= 0; i--) if (req[i]) grant_in = N'(1) << i;
      end

      for (int i = 0; i < N; i++) last[i] = ($urandom_range(0, lp) == 0);
      if (mode == 3 && m_own >= 0 && m_held == MAX_HOLD && $urandom_range(0, 1) == 1)
        last[m_own] = 1'b1;

      model_step(rst, req, grant_in, last);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arbiter_grant_lock.md
Name: arbiter_grant_lock

Overview:
- Sequential stage directly downstream of the combinational fixed-priority arbiter.
- Samples the arbiter's one-hot grant and locks it as bus ownership for a whole transaction, so a higher-priority request cannot steal the bus mid-transfer.
- Releases ownership on end-of-transaction, request drop, or a hold timeout, then inserts one turnaround cycle before re-arbitrating.
- Drives the shared-bus mux select and ownership status.

Parameters:
- N, 4, number of requesters; must match the upstream arbiter width.
- MAX_HOLD, 16, maximum cycles one owner may hold the bus; 0 disables the timeout.
- CNT_W, 8, hold-counter width; must satisfy MAX_HOLD <= 2**CNT_W - 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  raw request vector, the same vector that feeds the arbiter.
- grant_in  input  N  one-hot combinational grant from the fixed-priority arbiter.
- last  input  N  per-requester end-of-transaction strobe; only the owner's bit is used.
- grant  output  N  registered, locked one-hot grant to the bus.
- owner_id  output  $clog2(N)  binary index of the current owner; 0 when idle.
- bus_busy  output  1  high while an owner holds the bus.
- timeout  output  1  one-cycle pulse when ownership is revoked by MAX_HOLD.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, grant=0, owner_id=0, bus_busy=0, timeout=0, hold counter=0. Reset is honoured mid-transaction; ownership is dropped with no GAP cycle.
- States: IDLE, OWN, GAP.
- IDLE:
  - If |grant_in at edge t, then at t+1: grant=grant_in, owner_id=index, bus_busy=1, counter=0, state=OWN.
  - Otherwise stay in IDLE.
  - Latency from req to grant is one cycle.
- OWN:
  - Counter increments every cycle in OWN and saturates; it does not wrap.
  - Release if any of the following holds at edge t:
    - last[owner]=1 (transaction end), or
    - req[owner]=0 (requester abandoned), or
    - MAX_HOLD!=0 and counter==MAX_HOLD-1.
  - On release, at t+1: grant=0, bus_busy=0, state=GAP.
  - timeout=1 at t+1 only when the MAX_HOLD condition caused the release and last[owner]=0.
  - If last and timeout coincide, treat it as a normal end: timeout stays 0.
  - grant_in changes while in OWN are ignored; this is the lock.
  - last bits of non-owners are ignored.
- GAP:
  - Exactly one dead cycle with grant=0.
  - At the GAP edge, sample grant_in exactly as IDLE does: go to OWN if |grant_in, else to IDLE.
  - Back-to-back transactions therefore show one idle bus cycle between grants.
  - A timed-out owner that still requests competes again at normal priority. With N=4 fixed priority, a persistent req[0] re-wins.
- Malformed grant_in (more than one bit set): lock the lowest set bit only; grant must always be one-hot or zero.
- owner_id is held at its last value during GAP and cleared to 0 on entering IDLE.
- Timeout detection compares the registered counter; there is no combinational path from req/last to grant.

Decomposition:
- Package arb_pkg holds:
  - state enum (IDLE/OWN/GAP) as a 2-bit typedef;
  - default N and MAX_HOLD constants;
  - a clog2 function.
- Sub-module onehot_to_bin (N -> $clog2(N)) produces owner_id and selects last/req of the owner. It is reused by the bus mux.
- The hold counter and FSM stay in the top module.

Test Plan:
- Reset mid-OWN (req=0010 locked, assert rst) -> next cycle grant=0000, bus_busy=0, state IDLE, no timeout pulse.
- req=0100 at t, last[2] at t+4 -> grant=0100 from t+1 to t+4, grant=0000 at t+5 (GAP), bus_busy deasserted.
- Lock: owner req=1000 granted, then req=1001 (arbiter grant_in=0001) -> grant stays 1000 until last[3]; after GAP, grant=0001.
- MAX_HOLD=16, req[1] held, last never asserted -> grant=0010 for exactly 16 cycles, then timeout=1 for one cycle; after GAP, grant=0010 again.
- Coincidence: last[1] asserted on the cycle the counter hits MAX_HOLD-1 -> release with timeout=0.
- Owner drops req (req 0100->0000 mid-OWN) -> grant=0000 next cycle, GAP, then IDLE; malformed grant_in=0110 in IDLE -> grant=0010, owner_id=1.
